// File: rtl/branch_unit_pkg.sv
// Shared condition-code and FSM-state encodings for the branch unit and the decoder.
// Flag vectors are packed {Z,C,S,V}, MSB first.
package branch_unit_pkg;

  localparam logic [3:0] COND_NEVER = 4'd0;
  localparam logic [3:0] COND_BR    = 4'd1;
  localparam logic [3:0] COND_BZ    = 4'd2;
  localparam logic [3:0] COND_BNZ   = 4'd3;
  localparam logic [3:0] COND_BCY   = 4'd4;
  localparam logic [3:0] COND_BNCY  = 4'd5;
  localparam logic [3:0] COND_BS    = 4'd6;
  localparam logic [3:0] COND_BNS   = 4'd7;
  localparam logic [3:0] COND_BV    = 4'd8;
  localparam logic [3:0] COND_BNV   = 4'd9;
  localparam logic [3:0] COND_JR    = 4'd10;
  localparam logic [3:0] COND_CALL  = 4'd11;

  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_FLUSH = 1'b1;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator: (condition code, {Z,C,S,V}) -> cond_true.
module branch_cond_eval
  import branch_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_BR:   cond_true = 1'b1;
      COND_BZ:   cond_true = flags[FLAG_Z];
      COND_BNZ:  cond_true = !flags[FLAG_Z];
      COND_BCY:  cond_true = flags[FLAG_C];
      COND_BNCY: cond_true = !flags[FLAG_C];
      COND_BS:   cond_true = flags[FLAG_S];
      COND_BNS:  cond_true = !flags[FLAG_S];
      COND_BV:   cond_true = flags[FLAG_V];
      COND_BNV:  cond_true = !flags[FLAG_V];
      COND_JR:   cond_true = 1'b1;
      COND_CALL: cond_true = 1'b1;
      default:   cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Flag register, PC and branch resolution with a one-cycle wrong-path flush.
// Define FLAG_BYPASS_EN to let a branch see the flags of a same-cycle flag-setting op.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flag_we,
  input  logic            zFlag,
  input  logic            carryFlag,
  input  logic            signFlag,
  input  logic            overflowFlag,
  input  logic            br_valid,
  input  logic [3:0]      br_cond,
  input  logic [PC_W-1:0] br_off,
  input  logic [PC_W-1:0] rs_,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      flags,
  output logic            taken,
  output logic            flush,
  output logic            link_we,
  output logic [PC_W-1:0] link_addr
);

  logic [3:0]      alu_flags;
  logic [3:0]      eval_flags;
  logic            cond_true;
  logic            state;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] target;
  logic            rs_lo_unused;

  assign alu_flags    = {zFlag, carryFlag, signFlag, overflowFlag};
  assign rs_lo_unused = ^rs_[1:0];

`ifdef FLAG_BYPASS_EN
  assign eval_flags = flag_we ? alu_flags : flags;
`else
  assign eval_flags = flags;
`endif

  branch_cond_eval u_cond_eval (
    .cond      (br_cond),
    .flags     (eval_flags),
    .cond_true (cond_true)
  );

  assign pc_plus4  = pc + PC_W'(4);
  assign target    = (br_cond == COND_JR) ? {rs_[PC_W-1:2], 2'b00}
                                          : pc_plus4 + (br_off << 2);
  assign taken     = br_valid && cond_true && (state == ST_RUN) && !stall;
  assign link_we   = taken && (br_cond == COND_CALL);
  assign link_addr = pc_plus4;
  assign flush     = (state == ST_FLUSH);

  // Fetch/state boundary: a taken transfer always costs exactly one flushed slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      flags <= 4'b0000;
      state <= ST_RUN;
    end else if (!stall) begin
      pc    <= taken ? target : pc_plus4;
      state <= taken ? ST_FLUSH : ST_RUN;
      if (flag_we)
        flags <= alu_flags;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit with a scoreboard queue of expected values.
// Expectations for the same-cycle flag case follow FLAG_BYPASS_EN.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, flag_we;
  logic        zFlag, carryFlag, signFlag, overflowFlag;
  logic        br_valid;
  logic [3:0]  br_cond;
  logic [31:0] br_off, rs_;
  logic [31:0] pc, link_addr;
  logic [3:0]  flags;
  logic        taken, flush, link_we;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  int total = 0;
  int bad   = 0;

  branch_unit #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flag_we(flag_we),
    .zFlag(zFlag), .carryFlag(carryFlag), .signFlag(signFlag),
    .overflowFlag(overflowFlag), .br_valid(br_valid), .br_cond(br_cond),
    .br_off(br_off), .rs_(rs_), .pc(pc), .flags(flags), .taken(taken),
    .flush(flush), .link_we(link_we), .link_addr(link_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] exp);
    item_t it;
    it.tag = tag;
    it.exp = exp;
    q.push_back(it);
  endtask

  task automatic check(input logic [31:0] obs);
    item_t it;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty observed=%0h expected=queued_item", obs);
    end else begin
      it = q.pop_front();
      assert (obs === it.exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic set_flags(input logic [3:0] f);
    flag_we = 1'b1;
    {zFlag, carryFlag, signFlag, overflowFlag} = f;
    step();
    flag_we = 1'b0;
  endtask

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic z, cy, s, v;
    {z, cy, s, v} = f;
    case (c)
      4'd1, 4'd10, 4'd11: return 1'b1;
      4'd2: return z;
      4'd3: return ~z;
      4'd4: return cy;
      4'd5: return ~cy;
      4'd6: return s;
      4'd7: return ~s;
      4'd8: return v;
      4'd9: return ~v;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    logic [3:0] pats [2];
    logic       bypass;
`ifdef FLAG_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    pats[0] = 4'b1010;
    pats[1] = 4'b0101;

    rst = 1'b1; stall = 1'b1; flag_we = 1'b0;
    {zFlag, carryFlag, signFlag, overflowFlag} = 4'b0000;
    br_valid = 1'b0; br_cond = 4'd0; br_off = '0; rs_ = '0;

    // Reset held two clocks with stall asserted
    step(); step();
    expect_val("reset_pc", 32'h0);     check(pc);
    expect_val("reset_flags", 32'h0);  check({28'b0, flags});
    expect_val("reset_flush", 32'h0);  check({31'b0, flush});
    rst = 1'b0; stall = 1'b0;
    step();
    expect_val("first_free_pc", 32'h4); check(pc);

    // bz taken using registered flags
    step(); step(); step();
    expect_val("pc_0x10", 32'h10); check(pc);
    set_flags(4'b1000);
    expect_val("pc_0x14", 32'h14); check(pc);
    expect_val("flags_z", 32'h8);  check({28'b0, flags});
    br_valid = 1'b1; br_cond = 4'd2; br_off = 32'd3;
    #1;
    expect_val("bz_taken", 32'h1); check({31'b0, taken});
    step();
    br_valid = 1'b0;
    expect_val("bz_target", 32'h24); check(pc);
    expect_val("bz_flush", 32'h1);   check({31'b0, flush});
    step();
    expect_val("flush_clear", 32'h0); check({31'b0, flush});
    expect_val("pc_0x28", 32'h28);    check(pc);

    // Same-cycle flag write and bz
    set_flags(4'b0000);
    flag_we = 1'b1; {zFlag, carryFlag, signFlag, overflowFlag} = 4'b1000;
    br_valid = 1'b1; br_cond = 4'd2; br_off = 32'd0;
    #1;
    expect_val("bz_same_cycle_taken", {31'b0, bypass}); check({31'b0, taken});
    step();
    flag_we = 1'b0; br_valid = 1'b0;
    expect_val("same_cycle_flags", 32'h8);  check({28'b0, flags});
    expect_val("same_cycle_flush", {31'b0, bypass}); check({31'b0, flush});
    step();

    // jr aligns target; branch during FLUSH is ignored
    br_valid = 1'b1; br_cond = 4'd10; rs_ = 32'h103;
    #1;
    expect_val("jr_taken", 32'h1); check({31'b0, taken});
    expect_val("jr_link", 32'h0);  check({31'b0, link_we});
    step();
    expect_val("jr_pc", 32'h100); check(pc);
    br_cond = 4'd1; br_off = 32'd5;
    #1;
    expect_val("flush_ignore_taken", 32'h0); check({31'b0, taken});
    step();
    expect_val("flush_ignore_pc", 32'h104); check(pc);

    // call with PC wrap-around
    br_cond = 4'd10; rs_ = 32'hFFFF_FFF8;
    step();
    br_valid = 1'b0;
    step();
    expect_val("pre_call_pc", 32'hFFFF_FFFC); check(pc);
    br_valid = 1'b1; br_cond = 4'd11; br_off = 32'd0;
    #1;
    expect_val("call_taken", 32'h1);     check({31'b0, taken});
    expect_val("call_link_we", 32'h1);   check({31'b0, link_we});
    expect_val("call_link_addr", 32'h0); check(link_addr);
    step();
    br_valid = 1'b0;
    expect_val("call_pc_wrap", 32'h0); check(pc);
    step();
    expect_val("post_call_pc", 32'h4); check(pc);

    // Stall freezes everything and suppresses the branch
    stall = 1'b1; flag_we = 1'b1; {zFlag, carryFlag, signFlag, overflowFlag} = 4'b0111;
    br_valid = 1'b1; br_cond = 4'd1; br_off = 32'd8;
    #1;
    expect_val("stall_taken", 32'h0);   check({31'b0, taken});
    expect_val("stall_link_we", 32'h0); check({31'b0, link_we});
    step();
    expect_val("stall_pc", 32'h4);    check(pc);
    expect_val("stall_flags", 32'h8); check({28'b0, flags});
    expect_val("stall_flush", 32'h0); check({31'b0, flush});
    stall = 1'b0;
    #1;
    expect_val("unstall_taken", 32'h1); check({31'b0, taken});
    step();
    flag_we = 1'b0; br_valid = 1'b0;
    expect_val("unstall_pc", 32'h28);   check(pc);
    expect_val("unstall_flags", 32'h7); check({28'b0, flags});
    stall = 1'b1;
    step();
    expect_val("stall_hold_flush", 32'h1); check({31'b0, flush});
    expect_val("stall_hold_pc", 32'h28);   check(pc);

    // Reset while in FLUSH beats stall
    rst = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0;
    expect_val("midop_reset_pc", 32'h0);    check(pc);
    expect_val("midop_reset_flush", 32'h0); check({31'b0, flush});
    expect_val("midop_reset_flags", 32'h0); check({28'b0, flags});

    // Condition table sweep against two flag patterns
    foreach (pats[p]) begin
      set_flags(pats[p]);
      for (int c = 0; c < 16; c++) begin
        br_valid = 1'b1; br_cond = 4'(c); br_off = 32'd1; rs_ = 32'h40;
        #1;
        expect_val($sformatf("cond%0d_f%0h", c, pats[p]), {31'b0, ref_cond(4'(c), pats[p])});
        check({31'b0, taken});
        step();
        br_valid = 1'b0;
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
